// File: rtl/vx_writeback_arb.sv
// -----------------------------------------------------------------------------
// vx_writeback_arb
//
// Merges NUM_REQS writeback streams (ALU, LSU, FPU, SFU, ...) onto the single
// register-file writeback port. Sources are served round-robin. A writeback
// may span several beats, and its last beat carries eop. While a writeback is
// in progress the grant stays on its source, so beats of one writeback are
// never interleaved with beats from another source. The merged beat is held
// in a one-entry elastic output register. A new beat can be loaded in the
// same cycle the previous one drains, so a full-rate stream has no bubbles.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   req_valid  : [NUM_REQS] source i presents a beat
//   req_uuid   : [NUM_REQS][UUID_BITS] instruction uuid
//   req_tmask  : [NUM_REQS][NUM_THREADS] thread mask
//   req_wid    : [NUM_REQS][NW_BITS] warp id
//   req_PC     : [NUM_REQS][XLEN] instruction PC
//   req_rd     : [NUM_REQS][NR_BITS] destination register
//   req_data   : [NUM_REQS][NUM_THREADS][XLEN] per-lane data
//   req_eop    : [NUM_REQS] last beat of the writeback
//   req_ready  : [NUM_REQS] beat of source i accepted this cycle (one-hot/zero)
//   wb_*       : registered merged beat; wb_sel is the index of its source
//   wb_ready   : register file accepts the wb_* beat
// -----------------------------------------------------------------------------
module vx_writeback_arb #(
   parameter int NUM_REQS    = 4,
   parameter int NUM_THREADS = 4,
   parameter int XLEN        = 32,
   parameter int NR_BITS     = 6,
   parameter int NW_BITS     = 2,
   parameter int UUID_BITS   = 44,
   localparam int SEL_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic [NUM_REQS-1:0]                         req_valid,
   input  logic [NUM_REQS-1:0][UUID_BITS-1:0]          req_uuid,
   input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]        req_tmask,
   input  logic [NUM_REQS-1:0][NW_BITS-1:0]            req_wid,
   input  logic [NUM_REQS-1:0][XLEN-1:0]               req_PC,
   input  logic [NUM_REQS-1:0][NR_BITS-1:0]            req_rd,
   input  logic [NUM_REQS-1:0][NUM_THREADS-1:0][XLEN-1:0] req_data,
   input  logic [NUM_REQS-1:0]                         req_eop,
   output logic [NUM_REQS-1:0]                         req_ready,
   output logic                                        wb_valid,
   output logic [UUID_BITS-1:0]                        wb_uuid,
   output logic [NUM_THREADS-1:0]                      wb_tmask,
   output logic [NW_BITS-1:0]                          wb_wid,
   output logic [XLEN-1:0]                             wb_PC,
   output logic [NR_BITS-1:0]                          wb_rd,
   output logic [NUM_THREADS-1:0][XLEN-1:0]            wb_data,
   output logic                                        wb_eop,
   input  logic                                        wb_ready,
   output logic [SEL_W-1:0]                            wb_sel
);

   logic [SEL_W-1:0] rr_ptr_r;     // last source granted
   logic             locked_r;     // a multi-beat writeback is in progress
   logic [SEL_W-1:0] lock_idx_r;   // source owning the writeback in progress

   logic             stage_en_s;
   logic [SEL_W-1:0] grant_s;
   logic             grant_vld_s;
   logic             xfer_s;

   // Output stage can take a beat when empty or draining this cycle; never while reset is held.
   always_comb begin
      stage_en_s = reset && (!wb_valid || wb_ready);
   end

   // Grant: stick to the locked source, otherwise first valid source after rr_ptr_r, wrapping.
   always_comb begin
      int               idx;
      logic [SEL_W-1:0] cand;
      logic             hit;
      grant_s     = '0;
      grant_vld_s = 1'b0;
      idx         = 0;
      cand        = '0;
      hit         = 1'b0;
      if (locked_r) begin
         // An idle owner still blocks everyone else: no interleaving inside a writeback.
         grant_s     = lock_idx_r;
         grant_vld_s = req_valid[lock_idx_r];
      end else begin
         for (int i = 0; i < NUM_REQS; i++) begin
            idx         = int'(rr_ptr_r) + i + 32'sd1;
            idx         = (idx >= NUM_REQS) ? (idx - NUM_REQS) : idx;
            cand        = SEL_W'(idx);
            hit         = req_valid[cand] && !grant_vld_s;
            grant_s     = hit ? cand : grant_s;
            grant_vld_s = grant_vld_s || hit;
         end
      end
   end

   // One-hot ready for the granted source; depends only on valids and output-stage state.
   always_comb begin
      req_ready = '0;
      if (stage_en_s && grant_vld_s) begin
         req_ready[grant_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // A beat transfers whenever a valid source is granted into an available stage.
   always_comb begin
      xfer_s = stage_en_s && grant_vld_s;
   end

   // Output register, rotation pointer and writeback lock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid   <= 1'b0;
         wb_uuid    <= '0;
         wb_tmask   <= '0;
         wb_wid     <= '0;
         wb_PC      <= '0;
         wb_rd      <= '0;
         wb_data    <= '0;
         wb_eop     <= 1'b0;
         wb_sel     <= '0;
         // Pointing at the last source gives source 0 first priority.
         rr_ptr_r   <= SEL_W'(NUM_REQS - 1);
         locked_r   <= 1'b0;
         lock_idx_r <= '0;
      end else if (xfer_s) begin
         wb_valid   <= 1'b1;
         wb_uuid    <= req_uuid[grant_s];
         wb_tmask   <= req_tmask[grant_s];
         wb_wid     <= req_wid[grant_s];
         wb_PC      <= req_PC[grant_s];
         wb_rd      <= req_rd[grant_s];
         wb_data    <= req_data[grant_s];
         wb_eop     <= req_eop[grant_s];
         wb_sel     <= grant_s;
         rr_ptr_r   <= grant_s;
         // The eop beat releases the lock on the same edge it transfers.
         locked_r   <= !req_eop[grant_s];
         lock_idx_r <= grant_s;
      end else if (wb_valid && wb_ready) begin
         wb_valid   <= 1'b0;
      end else begin
         wb_valid   <= wb_valid;
      end
   end

endmodule

// File: doc/vx_writeback_arb.md
# vx_writeback_arb

Round-robin arbiter that merges `NUM_REQS` writeback streams into the single register-file writeback port. Execution units (ALU, LSU, FPU, SFU) produce writebacks that may span several beats, each beat a `valid/ready` transfer with `eop` set on the last beat. The arbiter keeps every multi-beat writeback contiguous by holding the grant until the `eop` beat, then passes to the next requester in rotation. The output is registered in a 1-entry elastic stage, so back-to-back transfers need no bubble cycles.

## Interface
Parameters:
- `NUM_REQS`, 4: number of writeback sources (≥1).
- `NUM_THREADS`, 4: lanes per beat.
- `XLEN`, 32: data width per lane.
- `NR_BITS`, 6: destination register index width.
- `NW_BITS`, 2: warp id width.
- `UUID_BITS`, 44: instruction uuid width.

Ports (per-request fields are packed arrays indexed `[NUM_REQS-1:0]`):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserts when 0).
- `req_valid` in NUM_REQS: source i presents a beat.
- `req_uuid` in NUM_REQS×UUID_BITS: instruction uuid.
- `req_tmask` in NUM_REQS×NUM_THREADS: thread mask.
- `req_wid` in NUM_REQS×NW_BITS: warp id.
- `req_PC` in NUM_REQS×XLEN: instruction PC.
- `req_rd` in NUM_REQS×NR_BITS: destination register.
- `req_data` in NUM_REQS×NUM_THREADS×XLEN: per-lane data.
- `req_eop` in NUM_REQS: last beat of this writeback.
- `req_ready` out NUM_REQS: beat of source i accepted this cycle.
- `wb_valid`, `wb_uuid`, `wb_tmask`, `wb_wid`, `wb_PC`, `wb_rd`, `wb_data`, `wb_eop` out (widths as the matching `req_*` field, one set): merged writeback.
- `wb_ready` in 1: register file accepts the `wb_*` beat.
- `wb_sel` out log2(NUM_REQS), minimum 1 bit: source index of the beat on `wb_*`.

## Operation
- State: `rr_ptr` (index of the last source granted), `locked` (1 bit), `lock_idx`, and the output register (`wb_*`, `wb_sel`, `wb_valid`).
- `stage_en = !wb_valid || wb_ready`. No source is granted unless `stage_en` is 1.

Grant selection, combinational:
- If `locked`, only `lock_idx` is eligible. Other sources stay ungranted even when `lock_idx` is idle; no interleaving inside a writeback.
- Otherwise the first valid source at or after `(rr_ptr+1) mod NUM_REQS`, wrapping around, is granted.
- `req_ready[i] = stage_en && grant==i && req_valid[i]`. The output is one-hot or all zero.

On each transfer of a beat from source g, i.e. `req_valid[g] && req_ready[g]`:
- The beat fields and `wb_sel = g` load into the output register; `wb_valid` is set to 1.
- `rr_ptr = g`.
- If `req_eop[g] = 0`: set `locked = 1` and `lock_idx = g`. Otherwise clear `locked`.

When `wb_valid && wb_ready` and no new beat is granted, `wb_valid` clears to 0.

Reset (`reset` = 0, asynchronous):
- `wb_valid`, `locked`, and all `wb_*` data fields go to 0; `wb_sel` goes to 0.
- `rr_ptr` goes to `NUM_REQS-1`, so source 0 has first priority.
- A partial writeback in flight is dropped and the lock is released.

The arbiter does not change payloads or inspect `tmask` or `rd`. A beat with `tmask` = 0 is forwarded like any other.

When `NUM_REQS = 1` the block degenerates to a registered pipe stage. `wb_sel` is then constant 0.

## Timing
- Latency: a beat accepted in cycle N appears on `wb_*` in cycle N+1.
- Throughput: 1 beat/cycle while `wb_ready` = 1.
- `req_ready` depends combinationally on `wb_valid`, `wb_ready` and `req_valid`. It never depends combinationally on `req_*` payload fields.
- Sources must hold `req_valid` and their payload stable until `req_ready` is 1.
- `wb_*` holds stable while `wb_valid && !wb_ready`.
- Rotation fairness: with all sources continuously valid and single-beat, grants cycle 0,1,…,NUM_REQS-1,0,… Each source waits at most `NUM_REQS-1` writebacks between grants.
- Lock release and re-arbitration:
  - The `eop` beat clears the lock in the same edge it transfers.
  - The next cycle, arbitration restarts at `lock_idx+1`.
  - No idle cycle is inserted between writebacks from different sources.

## Test plan
- **Reset values:** hold `reset` = 0 with all `req_valid` = 1 → `wb_valid` = 0 and `req_ready` = 0. Release reset → the first beat granted comes from source 0, and `wb_sel` = 0 one cycle later.
- **Round-robin rotation:** `NUM_REQS` = 4, all sources valid with `eop` = 1 every beat, `wb_ready` = 1 → `wb_sel` sequence is 0,1,2,3,0,1 on consecutive cycles, with `wb_valid` = 1 every cycle after the first.
- **Multi-beat lock:**
  - Stimulus: source 2 sends 3 beats with `eop` = 0,0,1 while sources 0 and 3 are continuously valid.
  - Required: the three source-2 beats appear contiguously, and then source 3 is granted next.
  - Same setup with source 2 dropping `req_valid` for 2 cycles between beats → no other source is granted during the gap.
- **Backpressure:** `wb_ready` = 0 for 5 cycles with source 1 valid → `wb_*` stays constant, `req_ready` = 0, and no beat is lost or duplicated. Raise `wb_ready` → beats resume 1 per cycle.
- **Reset mid-writeback:** assert `reset` after the first beat of a 2-beat writeback from source 1, with source 0 also valid. After release → `locked` is cleared and source 0 is granted first (`rr_ptr` = 3).
- **Scoreboard check:** random `req_valid`, `wb_ready` and beat counts over 10k cycles. Each source's beats must arrive in order and unmodified, each writeback's beats must be contiguous, and no source may wait longer than the fairness bound.
